// File: rtl/log_pkg.sv
// log_pkg: shared types and constants for the log_tx UART log transmitter.
// Optional feature macro: LOG_TX_PARITY_EN adds an even-parity bit per byte.
package log_pkg;

   // Log word geometry
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_W         = $clog2(BYTES_PER_WORD);

   // Serialiser FSM states; PARITY only exists when parity is compiled in
`ifdef LOG_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;
`endif

   // Reload value for the per-bit down-counter
   function automatic logic [15:0] bit_reload(input int unsigned clks_per_bit);
      return 16'(clks_per_bit - 1);
   endfunction

endpackage

// File: rtl/log_fifo.sv
// log_fifo: small synchronous FIFO for log words.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. Push while full and pop while empty
// are ignored so the caller cannot corrupt the pointers.
module log_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_ni,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Same index, different lap -> full; identical pointers -> empty
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Pointer update; both wrap modulo DEPTH with the extra bit toggling
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since empty masks them
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/log_tx.sv
// log_tx: buffers 32-bit log words and streams them out a UART line,
// four bytes per word, byte 0 first, each byte start/8 data LSB-first/stop.
// Optional macro LOG_TX_PARITY_EN inserts an even-parity bit before stop.
// tx_o is a registered copy of the current line level, so the line lags the
// FSM state by one cycle; busy_o is registered the same way so it drops in
// the first idle cycle after the final stop bit.
module log_tx
   import log_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset_ni,
   input  logic [WORD_W-1:0] log_data_i,
   input  logic              log_valid_i,
   output logic              log_ready_o,
   output logic              tx_o,
   output logic              busy_o
);

   localparam logic [15:0]       BIT_RELOAD = bit_reload(CLKS_PER_BIT);
   localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(BYTES_PER_WORD - 1);

   state_t              state;
   logic [15:0]         baud_cnt;
   logic [2:0]          bit_cnt;
   logic [BYTE_W-1:0]   byte_cnt;
   logic [WORD_W-1:0]   word_q;
`ifdef LOG_TX_PARITY_EN
   logic                par_q;
`endif

   logic                fifo_full;
   logic                fifo_empty;
   logic [WORD_W-1:0]   fifo_rdata;
   logic                push;
   logic                pop;
   logic                bit_end;
   logic                last_byte;
   logic                line_val;

   // Ready is purely "not full": a pop in the same cycle does not open it
   assign log_ready_o = !fifo_full;
   assign push        = log_valid_i && !fifo_full;
   assign bit_end     = (baud_cnt == '0);
   assign last_byte   = (byte_cnt == LAST_BYTE);

   // Fetch a word when idle, or at the end of the last stop bit of a word
   // so the next start bit follows with no idle gap
   assign pop = !fifo_empty &&
                ((state == ST_IDLE) ||
                 ((state == ST_STOP) && bit_end && last_byte));

   log_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_ni (reset_ni),
      .push     (push),
      .wdata    (log_data_i),
      .pop      (pop),
      .rdata    (fifo_rdata),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Line level implied by the current FSM state
   always_comb begin
      line_val = 1'b1;
      case (state)
         ST_START:  line_val = 1'b0;
         ST_DATA:   line_val = word_q[0];
`ifdef LOG_TX_PARITY_EN
         ST_PARITY: line_val = par_q;
`endif
         default:   line_val = 1'b1;
      endcase
   end

   // Serialiser FSM with registered line and busy outputs
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         word_q   <= '0;
`ifdef LOG_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
         tx_o     <= 1'b1;
         busy_o   <= 1'b0;
      end else begin
         tx_o   <= line_val;
         busy_o <= !fifo_empty || (state != ST_IDLE);

         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state    <= ST_START;
                  word_q   <= fifo_rdata;
                  byte_cnt <= '0;
                  baud_cnt <= BIT_RELOAD;
`ifdef LOG_TX_PARITY_EN
                  par_q    <= 1'b0;
`endif
               end
            end

            ST_START: begin
               if (bit_end) begin
                  state    <= ST_DATA;
                  bit_cnt  <= '0;
                  baud_cnt <= BIT_RELOAD;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  // Shifting the whole word leaves the next byte's LSB at bit 0
                  word_q   <= word_q >> 1;
                  bit_cnt  <= bit_cnt + 3'd1;
                  baud_cnt <= BIT_RELOAD;
`ifdef LOG_TX_PARITY_EN
                  par_q    <= par_q ^ word_q[0];
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
`else
                  if (bit_cnt == 3'd7) state <= ST_STOP;
`endif
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end

`ifdef LOG_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  state    <= ST_STOP;
                  baud_cnt <= BIT_RELOAD;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
`endif

            ST_STOP: begin
               if (bit_end) begin
                  if (!last_byte) begin
                     state    <= ST_START;
                     byte_cnt <= byte_cnt + 1'b1;
                     baud_cnt <= BIT_RELOAD;
`ifdef LOG_TX_PARITY_EN
                     par_q    <= 1'b0;
`endif
                  end else if (!fifo_empty) begin
                     // Word done and another is queued: chain straight into it
                     state    <= ST_START;
                     word_q   <= fifo_rdata;
                     byte_cnt <= '0;
                     baud_cnt <= BIT_RELOAD;
`ifdef LOG_TX_PARITY_EN
                     par_q    <= 1'b0;
`endif
                  end else begin
                     state    <= ST_IDLE;
                     byte_cnt <= '0;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
